// File: rtl/int_divider_if.sv
// Operand/result bundle between the arithmetic unit (master) and int_divider (slave).
interface int_divider_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             z;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;

   modport master (output x, y, input busy, z, q, r);
   modport slave  (input x, y, output busy, z, q, r);
endinterface

// File: rtl/int_divider.sv
// Multi-cycle signed restoring divider (idiv/irem, truncating, Java remainder sign).
// Optional macro DIV_ZERO_FAST_EN: y==0 skips the iteration and completes in one cycle.
module int_divider #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   int_divider_if.slave  div
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_ymag;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_qmag;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_sx;
   logic             r_neg;
   logic             r_z;
   logic [CW-1:0]    r_count;

   logic [WIDTH-1:0] w_xmag;
   logic [WIDTH-1:0] w_ymag;
   logic             w_y_zero;
   logic [WIDTH:0]   w_trial;
   logic             w_fit;
   logic [WIDTH-1:0] w_rem_next;

   // Unsigned magnitudes: -MIN wraps back to 2^(WIDTH-1), which is its true magnitude.
   assign w_xmag   = div.x[WIDTH-1] ? -div.x : div.x;
   assign w_ymag   = div.y[WIDTH-1] ? -div.y : div.y;
   assign w_y_zero = (div.y == '0);

   assign w_trial    = {r_rem, r_dvd[WIDTH-1]};
   assign w_fit      = (w_trial >= {1'b0, r_ymag});
   assign w_rem_next = w_fit ? WIDTH'(w_trial - {1'b0, r_ymag}) : w_trial[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
`ifdef DIV_ZERO_FAST_EN
            w_state_next = w_y_zero ? S_DONE : S_RUN;
`else
            w_state_next = S_RUN;
`endif
         end
         S_RUN:   if (r_count == CW'(WIDTH - 1)) w_state_next = S_FIX;
         S_FIX:   w_state_next = S_DONE;
         S_DONE:  w_state_next = S_DONE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q     <= '0;
         r_r     <= '0;
         r_z     <= 1'b0;
         r_count <= '0;
         r_dvd   <= '0;
         r_ymag  <= '0;
         r_rem   <= '0;
         r_qmag  <= '0;
         r_x     <= '0;
         r_sx    <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_dvd   <= w_xmag;
               r_ymag  <= w_ymag;
               r_x     <= div.x;
               r_sx    <= div.x[WIDTH-1];
               r_neg   <= div.x[WIDTH-1] ^ div.y[WIDTH-1];
               r_z     <= w_y_zero;
               r_rem   <= '0;
               r_qmag  <= '0;
               r_count <= '0;
`ifdef DIV_ZERO_FAST_EN
               if (w_y_zero) begin
                  r_q <= '1;
                  r_r <= div.x;
               end
`endif
            end
            S_RUN: begin
               r_rem   <= w_rem_next;
               r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
               r_qmag  <= {r_qmag[WIDTH-2:0], w_fit};
               r_count <= r_count + CW'(1);
            end
            S_FIX: begin
               // Zero divisor result is forced; the datapath value is meaningless then.
               if (r_z) begin
                  r_q <= '1;
                  r_r <= r_x;
               end else begin
                  r_q <= r_neg ? -r_qmag : r_qmag;
                  r_r <= r_sx  ? -r_rem  : r_rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign div.busy = ~rst & (r_state != S_DONE);
   assign div.q    = r_q;
   assign div.r    = r_r;
   assign div.z    = r_z;
endmodule

// File: tb/tb_int_divider.sv
// Randomised self-checking bench for int_divider against a plain-arithmetic division model.
module tb_int_divider;
   localparam int W = 32;
   localparam logic [W-1:0] MIN = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int_divider_if #(.WIDTH(W)) bus ();
   int_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .div(bus));

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] exp_q, exp_r, cur_x, cur_y;
   logic         exp_z = 1'b0;
   int           exp_lat = W + 2;
   int           busy_cycles = 0;
   logic         seen_done = 1'b0;
   logic         prev_rst = 1'b1;
   int           txn = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (x=%h y=%h)", name, act, req, cur_x, cur_y);
      end
   endtask

   // Reference: Java idiv/irem semantics from plain integer arithmetic.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] mq, output logic [W-1:0] mr, output logic mz);
      int sa, sb;
      sa = a;
      sb = b;
      mz = (b == 0);
      if (b == 0) begin
         mq = '1;
         mr = a;
      end else if (sb == -1) begin
         mq = -a;
         mr = '0;
      end else begin
         mq = sa / sb;
         mr = sa % sb;
      end
   endtask

   function automatic int latency_for(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
      return (b == 0) ? 1 : W + 2;
`else
      return W + 2;
`endif
   endfunction

   // Single compare process: every negedge outputs are meaningful in some way.
   always @(negedge clk) begin
      if (rst) begin
         check("busy_in_reset", W'(bus.busy), '0);
         if (prev_rst) begin
            check("q_in_reset", bus.q, '0);
            check("r_in_reset", bus.r, '0);
            check("z_in_reset", W'(bus.z), '0);
         end
         busy_cycles = 0;
         seen_done   = 1'b0;
      end else if (bus.busy) begin
         busy_cycles++;
         check("q_while_busy", bus.q, '0);
         check("r_while_busy", bus.r, '0);
      end else begin
         if (!seen_done) begin
            seen_done = 1'b1;
            txn++;
            check("latency", W'(busy_cycles), W'(exp_lat));
            $display("txn %0d: x=%h y=%h -> q=%h r=%h z=%b busy_cycles=%0d",
                     txn, cur_x, cur_y, bus.q, bus.r, bus.z, busy_cycles);
         end
         check("q", bus.q, exp_q);
         check("r", bus.r, exp_r);
         check("z", W'(bus.z), W'(exp_z));
      end
      prev_rst = rst;
   end

   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      rst   = 1'b1;
      bus.x = a;
      bus.y = b;
      cur_x = a;
      cur_y = b;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic finish_div();
      int k;
      k = 0;
      while (k < 100) begin
         @(posedge clk); #1;
         // Operands must be ignored once the division has started.
         bus.x = $urandom;
         bus.y = $urandom;
         if (!bus.busy) break;
         k++;
      end
      if (k >= 100) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: busy still 1 after %0d cycles, required 0", k);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic run_model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] mq, mr;
      logic mz;
      model(a, b, mq, mr, mz);
      exp_q = mq; exp_r = mr; exp_z = mz; exp_lat = latency_for(b);
      start(a, b);
      finish_div();
   endtask

   task automatic run_literal(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] lq, input logic [W-1:0] lr, input logic lz);
      logic [W-1:0] mq, mr;
      logic mz;
      cur_x = a;
      cur_y = b;
      model(a, b, mq, mr, mz);
      check("model_q", mq, lq);
      check("model_r", mr, lr);
      check("model_z", W'(mz), W'(lz));
      exp_q = lq; exp_r = lr; exp_z = lz; exp_lat = latency_for(b);
      start(a, b);
      finish_div();
   endtask

   initial begin
      logic [W-1:0] a, b;
      bus.x = '0;
      bus.y = '0;
      cur_x = '0;
      cur_y = '0;
      exp_q = '0;
      exp_r = '0;
      repeat (3) @(posedge clk);

      run_literal(32'd100,       32'd7,          32'd14,         32'd2,          1'b0);
      run_literal(-32'sd100,     32'd7,          -32'sd14,       -32'sd2,        1'b0);
      run_literal(32'd100,       -32'sd7,        -32'sd14,       32'd2,          1'b0);
      run_literal(-32'sd100,     -32'sd7,        32'd14,         -32'sd2,        1'b0);
      run_literal(MIN,           32'hFFFF_FFFF,  MIN,            32'd0,          1'b0);
      run_literal(MIN,           32'd1,          MIN,            32'd0,          1'b0);
      run_literal(32'd5,         32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1);
      run_literal(-32'sd9,       32'd0,          32'hFFFF_FFFF,  -32'sd9,        1'b1);
      run_literal(32'd3,         32'd10,         32'd0,          32'd3,          1'b0);

      // Abort mid-run, then restart cleanly.
      exp_q = '0; exp_r = '0; exp_z = 1'b0; exp_lat = W + 2;
      start(32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      run_literal(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      for (int i = 0; i < 50; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 3))
            0: ;
            1: b = ($urandom_range(0, 1) == 1) ? -W'($urandom_range(1, 20)) : W'($urandom_range(1, 20));
            2: a = MIN;
            default: begin
               a = W'($urandom_range(0, 1000));
               b = W'($urandom_range(1, 1000));
            end
         endcase
         if (b == 0) b = 32'd1;
         run_model(a, b);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
